// File: rtl/masked_bv8_inv_sched_pkg.sv
// Shared widths and types for the masked GF(2^8) inverse scheduler.
// Per-stage randomness counts assume HPC3 gadgets (two fresh bits per share pair).
package masked_bv8_inv_sched_pkg;

  localparam int unsigned SCHED_STAGES = 3;

  function automatic int unsigned share_pairs(int unsigned num_shares);
    return (num_shares * (num_shares - 1)) / 2;
  endfunction

  function automatic int unsigned gadget_factor(bit hpc3);
    return hpc3 ? 2 : 1;
  endfunction

  // Stage 1: GF(2^4) multiply, stage 2: GF(2^2) inverse core, stage 3: two GF(2^4) multiplies.
  function automatic int unsigned stage_1_randoms(int unsigned num_shares, bit hpc3);
    return 4 * share_pairs(num_shares) * gadget_factor(hpc3);
  endfunction

  function automatic int unsigned stage_2_randoms(int unsigned num_shares, bit hpc3);
    return 2 * share_pairs(num_shares) * gadget_factor(hpc3);
  endfunction

  function automatic int unsigned stage_3_randoms(int unsigned num_shares, bit hpc3);
    return 8 * share_pairs(num_shares) * gadget_factor(hpc3);
  endfunction

  localparam int unsigned DEF_NUM_SHARES = 2;
  localparam int unsigned DEF_R1_W = stage_1_randoms(DEF_NUM_SHARES, 1'b1);
  localparam int unsigned DEF_R2_W = stage_2_randoms(DEF_NUM_SHARES, 1'b1);
  localparam int unsigned DEF_R3_W = stage_3_randoms(DEF_NUM_SHARES, 1'b1);
  localparam int unsigned DEF_RAND_W = DEF_R1_W + DEF_R2_W + DEF_R3_W;

  typedef struct packed {
    logic [DEF_R3_W-1:0] s3;
    logic [DEF_R2_W-1:0] s2;
    logic [DEF_R1_W-1:0] s1;
  } rand_word_t;

endpackage

// File: rtl/masked_rand_fifo.sv
// Random-word buffer between the PRNG and the inverse scheduler.
// No bypass: a word written this cycle is visible at the head from the next cycle.
module masked_rand_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 28
) (
  input  logic                         in_clock,
  input  logic                         in_reset,
  input  logic                         in_valid,
  output logic                         out_ready,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_pop,
  output logic [WIDTH-1:0]             out_data,
  output logic [$clog2(DEPTH+1)-1:0]   out_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_level;
  logic             w_push;
  logic             w_pop;

  // Ready is forced low while reset is held so the PRNG never sees a phantom slot.
  assign out_ready = in_reset & (r_level != LW'(DEPTH));
  assign w_push    = in_valid & out_ready;
  assign w_pop     = in_pop & (r_level != '0);
  assign out_data  = r_mem[r_rptr];
  assign out_level = r_level;

  always_ff @(posedge in_clock) begin
    if (w_push) r_mem[r_wptr] <= in_data;
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/masked_bv8_inv_sched.sv
// Sequencer for the three-stage masked GF(2^8) inverse: admits an operation only with a full
// random word buffered, and steers each slice to its stage exactly once.
module masked_bv8_inv_sched
  import masked_bv8_inv_sched_pkg::*;
#(
  parameter int unsigned NUM_SHARES = DEF_NUM_SHARES,
  parameter int unsigned R1_W       = stage_1_randoms(NUM_SHARES, 1'b1),
  parameter int unsigned R2_W       = stage_2_randoms(NUM_SHARES, 1'b1),
  parameter int unsigned R3_W       = stage_3_randoms(NUM_SHARES, 1'b1),
  parameter int unsigned DEPTH      = 4
) (
  input  logic                           in_clock,
  input  logic                           in_reset,
  input  logic                           in_rand_valid,
  input  logic [R1_W+R2_W+R3_W-1:0]      in_rand,
  output logic                           out_rand_ready,
  input  logic                           in_valid,
  output logic                           out_ready,
  input  logic                           in_down_ready,
  output logic                           out_valid,
  output logic [SCHED_STAGES-1:0]        out_stage_en,
  output logic [R1_W-1:0]                out_rand_s1,
  output logic [R2_W-1:0]                out_rand_s2,
  output logic [R3_W-1:0]                out_rand_s3,
  output logic [$clog2(DEPTH+1)-1:0]     out_level
);

  localparam int unsigned RAND_W = R1_W + R2_W + R3_W;

  logic [RAND_W-1:0]          w_head;
  logic [$clog2(DEPTH+1)-1:0] w_level;
  logic                       w_adv;
  logic                       w_acc;
  logic [SCHED_STAGES-1:0]    r_v;
  logic [R2_W-1:0]            r_rs2;
  logic [R3_W-1:0]            r_q3;
  logic [R3_W-1:0]            r_rs3;

  masked_rand_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (RAND_W)
  ) u_fifo (
    .in_clock  (in_clock),
    .in_reset  (in_reset),
    .in_valid  (in_rand_valid),
    .out_ready (out_rand_ready),
    .in_data   (in_rand),
    .in_pop    (w_acc),
    .out_data  (w_head),
    .out_level (w_level)
  );

  // A bubble in the last stage never blocks, so the whole pipe only stalls on a held result.
  assign w_adv        = ~r_v[2] | in_down_ready;
  assign out_ready    = w_adv & (w_level != '0);
  assign w_acc        = in_valid & out_ready;
  assign out_stage_en = {w_adv & r_v[1], w_adv & r_v[0], w_acc};
  assign out_valid    = r_v[2];
  assign out_level    = w_level;

  assign out_rand_s1 = out_ready ? w_head[R1_W-1:0] : '0;
  assign out_rand_s2 = r_v[0] ? r_rs2 : '0;
  assign out_rand_s3 = r_v[1] ? r_rs3 : '0;

  // s3 bits wait one stage in r_q3 so a newly accepted word cannot overwrite the in-flight slice.
  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      r_v   <= '0;
      r_rs2 <= '0;
      r_q3  <= '0;
      r_rs3 <= '0;
    end else begin
      if (w_adv) r_v <= {r_v[1:0], w_acc};
      if (w_acc) begin
        r_rs2 <= w_head[R1_W +: R2_W];
        r_q3  <= w_head[R1_W+R2_W +: R3_W];
      end
      if (out_stage_en[1]) r_rs3 <= r_q3;
    end
  end

endmodule
